grf_wb_arbiter: RTL
===================

// Module: grf_wb_arbiter
// PURPOSE
//  Shares the single GRF write port (RFWr/A3/WD/PC) between NREQ write-back requesters
//  (e.g. ALU, load unit, mult/div unit) with round-robin arbitration and valid/ready handshakes.
//  Holds a per-register pending scoreboard so decode can stall on registers with writes in flight.
//  Sits between the execution units and GRF; its outputs drive GRF write inputs directly.
// PARAMETERS
//  NREQ  3  number of write-back requesters (2..8); requester i occupies slice i of packed buses
// PORTS
//  Clk          in   1         system clock, all state updates on posedge
//  Rst          in   1         synchronous reset, active-high
//  req_valid    in   NREQ      requester i has a write pending
//  req_a3       in   5*NREQ    destination register of requester i ([5i+4:5i])
//  req_wd       in   32*NREQ   write data of requester i
//  req_pc       in   32*NREQ   PC of the writing instruction (for GRF write log)
//  req_ready    out  NREQ      one-hot grant; write i accepted this cycle when valid&ready
//  issue_valid  in   1         decode issues an instruction that will write issue_a3
//  issue_a3     in   5         destination register being issued
//  A1           in   5         decode read address 1
//  A2           in   5         decode read address 2
//  busy1        out  1         register A1 has a write in flight (0 when A1==0)
//  busy2        out  1         register A2 has a write in flight (0 when A2==0)
//  RFWr         out  1         GRF write enable (registered)
//  A3           out  5         GRF write address (registered)
//  WD           out  32        GRF write data (registered)
//  PC           out  32        GRF write PC (registered)
// BEHAVIOUR
//  - Reset (Rst=1 at posedge): RFWr=0, A3=0, WD=0, PC=0, rr_ptr=0, scoreboard all 0.
//    req_ready is 0 while Rst=1. Reset mid-grant discards the granted write.
//  - Arbitration (combinational): search req_valid starting at rr_ptr, wrapping NREQ-1 -> 0;
//    first valid index g gets req_ready[g]=1; all other ready bits 0. No valid -> ready=0.
//  - Requester holds valid, a3, wd, pc stable until its ready; valid may not drop unaccepted.
//  - On grant g: rr_ptr <= (g+1) mod NREQ; no grant -> rr_ptr unchanged.
//  - Output stage, 1-cycle latency: cycle after grant RFWr=1, A3/WD/PC = granted fields.
//    Cycle without grant: RFWr=0; A3/WD/PC keep last value.
//  - Grant with a3==0: accepted (ready=1, rr_ptr advances) but RFWr stays 0 next cycle.
//  - Throughput: one write per cycle back-to-back; no bubbles between consecutive grants.
//  - Scoreboard busy[31:1] (busy[0] hardwired 0):
//    issue_valid & issue_a3!=0 -> busy[issue_a3] <= 1 next cycle.
//    grant of register r -> busy[r] <= 0 next cycle.
//    Same register issued and granted same cycle: set wins (busy stays 1).
//    Issue of an already-busy register: stays 1 (no counting; decode stalls on busy first).
//  - busy1 = busy[A1] & (A1!=0); busy2 likewise; combinational from current state,
//    no bypass of same-cycle issue/grant.
//  - Widths: all register-number arithmetic 5-bit; rr_ptr is $clog2(NREQ) bits, wrap explicit.
// TESTING
//  1 Reset: Rst=1 two cycles with all req_valid=1 -> req_ready=0, RFWr=0, A3=0, WD=0, busy1/2=0.
//  2 Single: req0 a3=5 wd=32'h1234_5678 pc=32'h3000 -> ready=3'b001 cycle t; t+1 RFWr=1,
//    A3=5, WD=32'h1234_5678, PC=32'h3000; t+2 RFWr=0.
//  3 Round-robin: all three valid constantly (a3=1,2,3) from reset -> grants 0,1,2,0,1,2;
//    RFWr=1 every cycle, A3 sequence 1,2,3,1,2,3.
//  4 $0 write: req1 a3=0 wd=32'hFFFF_FFFF -> ready[1]=1, next cycle RFWr=0, rr_ptr=2.
//  5 Scoreboard: issue a3=7, A1=7 -> busy1=1 next cycle; grant a3=7 -> busy1=0 cycle after;
//    issue 7 and grant 7 same cycle -> busy1 stays 1; A2=0 -> busy2=0 always.
//  6 Hold: req2 valid while rr_ptr points at 0 and req0/req1 valid -> req2 waits at most
//    2 cycles, data stable, then written with its exact a3/wd/pc.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the GRF write port between NREQ write-back units,
// with a per-register pending scoreboard that decode uses to stall on in-flight writes.
module grf_wb_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [5*NREQ-1:0] req_a3,
   input  logic [32*NREQ-1:0] req_wd,
   input  logic [32*NREQ-1:0] req_pc,
   output logic [NREQ-1:0]   req_ready,
   input  logic              issue_valid,
   input  logic [4:0]        issue_a3,
   input  logic [4:0]        A1,
   input  logic [4:0]        A2,
   output logic              busy1,
   output logic              busy2,
   output logic              RFWr,
   output logic [4:0]        A3,
   output logic [31:0]       WD,
   output logic [31:0]       PC
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_q, rr_d;
   logic [PW:0]     scan;
   logic [PW-1:0]   cand;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [NREQ-1:0] gnt;
   logic [4:0]      gnt_a3;
   logic [31:0]     gnt_wd, gnt_pc;
   logic [31:0]     busy_q, busy_d;

   // Scan from rr_q upwards, wrapping explicitly at NREQ; first valid requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      scan    = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, rr_q} + (PW+1)'(k);
         if (scan >= (PW+1)'(NREQ)) begin
            scan = scan - (PW+1)'(NREQ);
         end
         cand = scan[PW-1:0];
         if (!gnt_any && !Rst && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      gnt_a3 = '0;
      gnt_wd = '0;
      gnt_pc = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_a3 = req_a3[5*i +: 5];
            gnt_wd = req_wd[32*i +: 32];
            gnt_pc = req_pc[32*i +: 32];
         end
      end
   end

   assign req_ready = gnt;

   always_comb begin
      rr_d = rr_q;
      if (gnt_any) begin
         rr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Clear on grant first so that a same-cycle issue of that register keeps it pending.
   always_comb begin
      busy_d = busy_q;
      if (gnt_any && gnt_a3 != 5'd0) begin
         busy_d[gnt_a3] = 1'b0;
      end
      if (issue_valid && issue_a3 != 5'd0) begin
         busy_d[issue_a3] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign busy1 = busy_q[A1] & (A1 != 5'd0);
   assign busy2 = busy_q[A2] & (A2 != 5'd0);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rr_q   <= '0;
         busy_q <= '0;
         RFWr   <= 1'b0;
         A3     <= '0;
         WD     <= '0;
         PC     <= '0;
      end else begin
         rr_q   <= rr_d;
         busy_q <= busy_d;
         RFWr   <= gnt_any && (gnt_a3 != 5'd0);
         if (gnt_any) begin
            A3 <= gnt_a3;
            WD <= gnt_wd;
            PC <= gnt_pc;
         end
      end
   end

endmodule
